// File: rtl/adc_seq_ctrl.sv
// -----------------------------------------------------------------------------
// adc_seq_ctrl
// Conversion sequencer for the SAR ADC + OSR accumulator. Walks a list of up to
// four slots; each slot selects an analog channel and an OSR mode, settles with
// the accumulator held cleared, enables conversions until the OSR reports a
// finished result (or a timeout expires), then hands the 16-bit result to the
// host over a valid/ready handshake.
//
// Ports
//   clk, rst_n           : controller clock, asynchronous active-low reset
//   start_in             : starts a sequence when sampled high in IDLE
//   abort_in             : returns to IDLE from any state (highest priority)
//   continuous_in        : latched at start, repeat the slot list until abort
//   seq_len_in[1:0]      : last slot index, latched at start
//   ch_cfg_in[7:0]       : slot n channel  = ch_cfg_in[2n+1:2n]
//   osr_cfg_in[11:0]     : slot n OSR mode = osr_cfg_in[3n+2:3n]
//   osr_done_in          : OSR conversion finished (level, used in CONVERT only)
//   osr_data_in[15:0]    : OSR result, valid with osr_done_in
//   adc_ch_out[1:0]      : analog mux channel select
//   osr_mode_out[2:0]    : OSR mode
//   osr_clr_out          : holds the OSR accumulator cleared
//   adc_en_out           : enables SAR conversions
//   result_out[15:0]     : captured result (16'hFFFF on timeout)
//   result_slot_out[1:0] : slot index belonging to result_out
//   result_valid_out     : result handshake valid
//   result_ready_in      : result handshake ready
//   busy_out             : high whenever the sequencer is not IDLE
//   timeout_err_out      : sticky timeout flag, cleared by the next start
// All outputs are registered.
// -----------------------------------------------------------------------------
module adc_seq_ctrl #(
  parameter int SETTLE_CYCLES  = 4,       // 1..255
  parameter int TIMEOUT_CYCLES = 16'hFFFF // 0 disables the timeout
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_in,
  input  logic        abort_in,
  input  logic        continuous_in,
  input  logic [1:0]  seq_len_in,
  input  logic [7:0]  ch_cfg_in,
  input  logic [11:0] osr_cfg_in,
  input  logic        osr_done_in,
  input  logic [15:0] osr_data_in,
  output logic [1:0]  adc_ch_out,
  output logic [2:0]  osr_mode_out,
  output logic        osr_clr_out,
  output logic        adc_en_out,
  output logic [15:0] result_out,
  output logic [1:0]  result_slot_out,
  output logic        result_valid_out,
  input  logic        result_ready_in,
  output logic        busy_out,
  output logic        timeout_err_out
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CONVERT = 2'd2,
    ST_DELIVER = 2'd3
  } state_t;

  // Settle counter is loaded with N-1 so that SETTLE lasts exactly N cycles.
  localparam logic [7:0]  SETTLE_LOAD  = 8'(SETTLE_CYCLES - 1);
  // CONVERT cycle k ends with r_tmo_cnt == k-1, so the timeout fires on the
  // edge that closes CONVERT cycle TIMEOUT_CYCLES.
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic        TIMEOUT_EN   = (TIMEOUT_CYCLES != 0) ? 1'b1 : 1'b0;

  state_t      r_state;
  logic [1:0]  r_slot;
  logic [1:0]  r_seq_len;
  logic [7:0]  r_ch_cfg;
  logic [11:0] r_osr_cfg;
  logic        r_continuous;
  logic [7:0]  r_settle_cnt;
  logic [15:0] r_tmo_cnt;

  logic        w_last_slot;
  logic [1:0]  w_next_slot;
  logic        w_transfer;
  logic        w_timeout;

  // Channel field of a slot from a packed channel list.
  function automatic logic [1:0] slot_ch(input logic [7:0] cfg, input logic [1:0] slot);
    logic [1:0] ch;
    case (slot)
      2'd0:    ch = cfg[1:0];
      2'd1:    ch = cfg[3:2];
      2'd2:    ch = cfg[5:4];
      2'd3:    ch = cfg[7:6];
      default: ch = 2'd0;
    endcase
    return ch;
  endfunction

  // OSR mode field of a slot from a packed mode list.
  function automatic logic [2:0] slot_mode(input logic [11:0] cfg, input logic [1:0] slot);
    logic [2:0] mode;
    case (slot)
      2'd0:    mode = cfg[2:0];
      2'd1:    mode = cfg[5:3];
      2'd2:    mode = cfg[8:6];
      2'd3:    mode = cfg[11:9];
      default: mode = 3'd0;
    endcase
    return mode;
  endfunction

  assign w_last_slot = (r_slot == r_seq_len);
  assign w_next_slot = w_last_slot ? 2'd0 : (r_slot + 2'd1);
  assign w_transfer  = result_valid_out & result_ready_in;
  assign w_timeout   = TIMEOUT_EN & (r_tmo_cnt == TIMEOUT_LAST);

  // Sequencer FSM with all outputs and latched configuration registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= ST_IDLE;
      r_slot           <= 2'd0;
      r_seq_len        <= 2'd0;
      r_ch_cfg         <= 8'd0;
      r_osr_cfg        <= 12'd0;
      r_continuous     <= 1'b0;
      r_settle_cnt     <= 8'd0;
      r_tmo_cnt        <= 16'd0;
      adc_ch_out       <= 2'd0;
      osr_mode_out     <= 3'd0;
      osr_clr_out      <= 1'b0;
      adc_en_out       <= 1'b0;
      result_out       <= 16'd0;
      result_slot_out  <= 2'd0;
      result_valid_out <= 1'b0;
      busy_out         <= 1'b0;
      timeout_err_out  <= 1'b0;
    end else if (abort_in) begin
      // Abort drops any pending result but keeps the sticky timeout flag.
      r_state          <= ST_IDLE;
      result_valid_out <= 1'b0;
      adc_en_out       <= 1'b0;
      osr_clr_out      <= 1'b1;
      busy_out         <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          busy_out         <= 1'b0;
          osr_clr_out      <= 1'b1;
          adc_en_out       <= 1'b0;
          result_valid_out <= 1'b0;
          if (start_in) begin
            r_seq_len       <= seq_len_in;
            r_ch_cfg        <= ch_cfg_in;
            r_osr_cfg       <= osr_cfg_in;
            r_continuous    <= continuous_in;
            r_slot          <= 2'd0;
            r_settle_cnt    <= SETTLE_LOAD;
            timeout_err_out <= 1'b0;
            // Mux and mode are driven from the first SETTLE cycle.
            adc_ch_out      <= slot_ch(ch_cfg_in, 2'd0);
            osr_mode_out    <= slot_mode(osr_cfg_in, 2'd0);
            busy_out        <= 1'b1;
            r_state         <= ST_SETTLE;
          end else begin
            r_state <= ST_IDLE;
          end
        end

        ST_SETTLE: begin
          if (r_settle_cnt == 8'd0) begin
            osr_clr_out <= 1'b0;
            adc_en_out  <= 1'b1;
            r_tmo_cnt   <= 16'd0;
            r_state     <= ST_CONVERT;
          end else begin
            r_settle_cnt <= r_settle_cnt - 8'd1;
          end
        end

        ST_CONVERT: begin
          // A real result beats a coincident timeout.
          if (osr_done_in) begin
            result_out       <= osr_data_in;
            result_slot_out  <= r_slot;
            result_valid_out <= 1'b1;
            adc_en_out       <= 1'b0;
            osr_clr_out      <= 1'b1;
            r_state          <= ST_DELIVER;
          end else if (w_timeout) begin
            result_out       <= 16'hFFFF;
            result_slot_out  <= r_slot;
            result_valid_out <= 1'b1;
            timeout_err_out  <= 1'b1;
            adc_en_out       <= 1'b0;
            osr_clr_out      <= 1'b1;
            r_state          <= ST_DELIVER;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 16'd1;
          end
        end

        ST_DELIVER: begin
          if (w_transfer) begin
            result_valid_out <= 1'b0;
            if (!w_last_slot || r_continuous) begin
              r_slot       <= w_next_slot;
              adc_ch_out   <= slot_ch(r_ch_cfg, w_next_slot);
              osr_mode_out <= slot_mode(r_osr_cfg, w_next_slot);
              r_settle_cnt <= SETTLE_LOAD;
              r_state      <= ST_SETTLE;
            end else begin
              busy_out <= 1'b0;
              r_state  <= ST_IDLE;
            end
          end else begin
            r_state <= ST_DELIVER;
          end
        end

        default: begin
          r_state          <= ST_IDLE;
          result_valid_out <= 1'b0;
          adc_en_out       <= 1'b0;
          osr_clr_out      <= 1'b1;
          busy_out         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/adc_seq_ctrl.md
Name: adc_seq_ctrl

Overview:
Conversion sequencer that schedules the SAR ADC plus OSR accumulator over a programmable list of up to 4 slots. Each slot has its own input-channel select and OSR mode. Per slot it:
- switches the channel mux and holds the OSR cleared for a settle time;
- enables conversions and waits for the OSR completion flag;
- hands the 16-bit result to the host through a valid/ready handshake.
Sits between the host/register block and the adc_osr datapath.

Parameters:
SETTLE_CYCLES, 4, clk cycles between channel/mode switch and conversion enable (1..255)
TIMEOUT_CYCLES, 16'hFFFF, max clk cycles in CONVERT before abort; 0 disables timeout

Ports:
clk  in  1  controller clock
rst_n  in  1  asynchronous active-low reset
start_in  in  1  sampled high in IDLE starts a sequence
abort_in  in  1  forces return to IDLE from any state
continuous_in  in  1  latched at start; 1 = repeat sequence until abort
seq_len_in  in  2  last slot index (0..3), latched at start
ch_cfg_in  in  8  slot n channel = ch_cfg_in[2n+1:2n], latched at start
osr_cfg_in  in  12  slot n OSR mode = osr_cfg_in[3n+2:3n], latched at start
osr_done_in  in  1  conversion_finished from OSR, level, valid in CONVERT only
osr_data_in  in  16  OSR result, valid when osr_done_in=1
adc_ch_out  out  2  channel select to analog mux
osr_mode_out  out  3  OSR mode to accumulator
osr_clr_out  out  1  holds OSR accumulator cleared (drives OSR rst_n low when 1)
adc_en_out  out  1  enables SAR conversions / data_valid_strobe generation
result_out  out  16  captured result
result_slot_out  out  2  slot index of result_out
result_valid_out  out  1  result handshake valid
result_ready_in  in  1  result handshake ready
busy_out  out  1  1 in any state except IDLE
timeout_err_out  out  1  sticky; cleared by next accepted start_in

Behaviour:
- All outputs registered. Reset: state=IDLE, all outputs 0, latched config 0.
- FSM states: IDLE, SETTLE, CONVERT, DELIVER.
- IDLE:
  - busy=0, osr_clr=1, adc_en=0.
  - start_in=1 -> latch seq_len/ch_cfg/osr_cfg/continuous, slot=0, clear timeout_err, load settle counter, go SETTLE.
- SETTLE:
  - adc_ch_out/osr_mode_out = current slot config, valid from the first SETTLE cycle.
  - osr_clr=1, adc_en=0.
  - Stay exactly SETTLE_CYCLES cycles, then go CONVERT.
- CONVERT:
  - osr_clr=0, adc_en=1.
  - osr_done_in=1 -> capture osr_data_in into result_out, slot into result_slot_out, go DELIVER.
  - Timeout counter reaches TIMEOUT_CYCLES (if nonzero) -> result_out=16'hFFFF, timeout_err=1, go DELIVER.
  - osr_done and timeout on the same cycle: done wins, no error.
- DELIVER:
  - adc_en=0, osr_clr=1, result_valid=1.
  - result_out stays stable until result_ready_in=1 (valid&ready = transfer).
  - On transfer: result_valid=0 next cycle.
    - slot<seq_len -> slot+1, go SETTLE.
    - slot==seq_len and continuous latched -> slot=0, go SETTLE.
    - Otherwise go IDLE.
- Latency: start_in sampled at edge N -> busy=1 after N. adc_en rises after edge N+SETTLE_CYCLES. A ready held high gives a 1-cycle DELIVER.
- abort_in: highest priority in every state. Next edge -> IDLE, result_valid=0, adc_en=0, osr_clr=1. An undelivered result is dropped; timeout_err is kept. abort_in together with start_in in IDLE -> stays IDLE.
- start_in outside IDLE is ignored. Config input changes mid-sequence have no effect until the next start.
- osr_done_in is ignored outside CONVERT. osr_clr during SETTLE guarantees the OSR flag is stale-free.

Test Plan:
- SETTLE_CYCLES=4. seq_len=0, ch_cfg=8'h03, osr_cfg=3'b001, start pulse. OSR model asserts done with 16'h0018. -> adc_ch_out=3 and osr_mode=1 from cycle 1; adc_en rises at cycle 5; result_out=16'h0018, slot=0, valid until ready; then busy=0.
- seq_len=3, channels {0,1,2,3}, modes {0,1,2,3}, model returns 16'h1000+slot, ready tied 1. -> four results 16'h1000..16'h1003 with slot 0..3 in order; return to IDLE.
- Backpressure: ready low for 10 cycles in DELIVER. -> result_out/result_valid stable all 10 cycles; adc_en=0; no slot advance.
- continuous=1, seq_len=1. -> slots 0,1,0,1,... repeat. Abort mid-CONVERT -> IDLE next edge; adc_en=0; no further result_valid.
- TIMEOUT_CYCLES=20, done never asserted. -> result_out=16'hFFFF at CONVERT cycle 20, timeout_err=1. Next start clears timeout_err.
- Async reset asserted mid-SETTLE and released. -> all outputs 0 immediately, IDLE. Done pulses before start produce no result_valid.
